rv32_regfile_sb: RTL and testbench

RV32_REGFILE_SB -- requirements
Module: rv32_regfile_sb

---
 rtl/rv32_regfile_sb.sv | 124 ++++++++++++
 tb/tb_rv32_regfile_sb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_regfile_sb.sv
// rtl/rv32_regfile_sb.sv - RV32 register file with busy-bit scoreboard and NWB writeback ports
// Define REGFILE_WB_BYPASS_EN to forward same-cycle writeback data and release hazards early.
module rv32_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NWB   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        rs1_sel,
  input  logic [AW-1:0]        rs2_sel,
  input  logic [AW-1:0]        rd_sel,
  input  logic                 rd_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      rs1_value,
  output logic [XLEN-1:0]      rs2_value,
  input  logic [NWB-1:0]       wb_en,
  input  logic [NWB*AW-1:0]    wb_sel,
  input  logic [NWB*XLEN-1:0]  wb_data,
  input  logic                 flush,
  output logic [15:0]          stall_cnt
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_rs1_value;
  logic [XLEN-1:0]  r_rs2_value;
  logic [15:0]      r_stall_cnt;

  logic [NREGS-1:0] w_wb_clr;
  logic [NREGS-1:0] w_eff_busy;
  logic [NREGS-1:0] w_busy_next;
  logic             w_hazard;
  logic             w_accept;
  logic             w_stall;
  logic [XLEN-1:0]  w_rs1_rd;
  logic [XLEN-1:0]  w_rs2_rd;

  function automatic logic [XLEN-1:0] f_read(input logic [AW-1:0] sel);
    logic [XLEN-1:0] v;
    v = (sel == '0) ? '0 : r_regs[sel];
`ifdef REGFILE_WB_BYPASS_EN
    // ascending scan so the highest-numbered matching port is the one forwarded
    for (int k = 0; k < NWB; k++) begin
      if (wb_en[k] && (sel != '0) && (wb_sel[k*AW +: AW] == sel))
        v = wb_data[k*XLEN +: XLEN];
    end
`endif
    return v;
  endfunction

  always_comb begin
    w_wb_clr = '0;
    for (int k = 0; k < NWB; k++) begin
      if (wb_en[k] && (wb_sel[k*AW +: AW] != '0))
        w_wb_clr[wb_sel[k*AW +: AW]] = 1'b1;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign w_eff_busy = r_busy & ~w_wb_clr;
`else
  assign w_eff_busy = r_busy;
`endif

  assign w_hazard = w_eff_busy[rs1_sel] | w_eff_busy[rs2_sel] | (rd_en & w_eff_busy[rd_sel]);
  assign in_ready = (~r_out_valid | out_ready) & ~w_hazard & ~flush;
  assign w_accept = in_valid & in_ready;
  assign w_stall  = in_valid & ~in_ready;
  assign w_rs1_rd = f_read(rs1_sel);
  assign w_rs2_rd = f_read(rs2_sel);

  always_comb begin
    w_busy_next = r_busy & ~w_wb_clr;
    // a new reservation wins over a writeback clearing the same register
    if (w_accept && rd_en && (rd_sel != '0))
      w_busy_next[rd_sel] = 1'b1;
    if (flush)
      w_busy_next = '0;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREGS; r++)
        r_regs[r] <= '0;
      r_busy      <= '0;
      r_out_valid <= 1'b0;
      r_rs1_value <= '0;
      r_rs2_value <= '0;
      r_stall_cnt <= '0;
    end else begin
      // later ports overwrite earlier ones on an index collision
      for (int k = 0; k < NWB; k++) begin
        if (wb_en[k] && (wb_sel[k*AW +: AW] != '0))
          r_regs[wb_sel[k*AW +: AW]] <= wb_data[k*XLEN +: XLEN];
      end
      r_busy <= w_busy_next;
      if (flush)
        r_out_valid <= 1'b0;
      else if (w_accept)
        r_out_valid <= 1'b1;
      else if (out_ready)
        r_out_valid <= 1'b0;
      if (w_accept) begin
        r_rs1_value <= w_rs1_rd;
        r_rs2_value <= w_rs2_rd;
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign out_valid = r_out_valid;
  assign rs1_value = r_rs1_value;
  assign rs2_value = r_rs2_value;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_rv32_regfile_sb.sv
// tb/tb_rv32_regfile_sb.sv - directed scoreboard bench for rv32_regfile_sb
// Expected timing follows REGFILE_WB_BYPASS_EN when it is defined for the build.
module tb_rv32_regfile_sb;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;
  logic [4:0]  rd_sel;
  logic        rd_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic [1:0]  wb_en;
  logic [9:0]  wb_sel;
  logic [63:0] wb_data;
  logic        flush;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  logic [63:0] exp_q [$];

  rv32_regfile_sb dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1_sel   (rs1_sel),
    .rs2_sel   (rs2_sel),
    .rd_sel    (rd_sel),
    .rd_en     (rd_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rs1_value (rs1_value),
    .rs2_value (rs2_value),
    .wb_en     (wb_en),
    .wb_sel    (wb_sel),
    .wb_data   (wb_data),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic issue(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] rd, input logic en);
    in_valid = v;
    rs1_sel  = s1;
    rs2_sel  = s2;
    rd_sel   = rd;
    rd_en    = en;
  endtask

  task automatic set_wb(input logic [1:0] en, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [31:0] d0, input logic [31:0] d1);
    wb_en   = en;
    wb_sel  = {s1, s0};
    wb_data = {d1, d0};
  endtask

  // output side of the scoreboard: every completed output handshake pops one entry
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 32'(out_valid), 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("sb_rs1_value", rs1_value, e[63:32]);
        check("sb_rs2_value", rs2_value, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn    = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    // activity during reset must be discarded
    issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
    set_wb(2'b01, 5'd4, 5'd0, 32'h55, 32'h0);
    at_neg();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_rs1", rs1_value, 32'd0);
    check("reset_rs2", rs2_value, 32'd0);
    check("reset_stall", 32'(stall_cnt), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    resetn = 1'b1;
    at_neg();
    check("post_reset_out_valid", 32'(out_valid), 32'd0);
    tick();

    // x5 = DEADBEEF, then read it with x0
    set_wb(2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0);
    tick();
    set_wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    issue(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    exp_q.push_back({32'hDEAD_BEEF, 32'h0});
    at_neg();
    check("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    at_neg();
    check("t1_latency_out_valid", 32'(out_valid), 32'd1);
    tick();
    // x4 was written and reserved only during reset: must read 0 and not stall
    issue(1'b1, 5'd4, 5'd5, 5'd0, 1'b0);
    exp_q.push_back({32'h0, 32'hDEAD_BEEF});
    at_neg();
    check("t1_x4_not_busy", 32'(in_ready), 32'd1);
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    at_neg();
    tick();

    // RAW stall on x7 until writeback on port 1
    issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    exp_q.push_back({32'h0, 32'h0});
    at_neg();
    check("t2_rd7_in_ready", 32'(in_ready), 32'd1);
    tick();
    issue(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
    at_neg();
    check("t2_raw_in_ready", 32'(in_ready), 32'd0);
    tick();
    exp_stall = 1;
    at_neg();
    check("t2_stall_1", 32'(stall_cnt), 32'(exp_stall));
    check("t2_raw_in_ready_2", 32'(in_ready), 32'd0);
    tick();
    exp_stall = 2;
    set_wb(2'b10, 5'd0, 5'd7, 32'h0, 32'h11);
`ifdef REGFILE_WB_BYPASS_EN
    exp_q.push_back({32'h11, 32'h0});
    at_neg();
    check("t2_bypass_in_ready", 32'(in_ready), 32'd1);
    tick();
    set_wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    at_neg();
    check("t2_stall_frozen", 32'(stall_cnt), 32'(exp_stall));
    check("t2_out_valid", 32'(out_valid), 32'd1);
    tick();
`else
    at_neg();
    check("t2_wb_cycle_in_ready", 32'(in_ready), 32'd0);
    tick();
    exp_stall = 3;
    set_wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    exp_q.push_back({32'h11, 32'h0});
    at_neg();
    check("t2_stall_3", 32'(stall_cnt), 32'(exp_stall));
    check("t2_late_in_ready", 32'(in_ready), 32'd1);
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    at_neg();
    check("t2_out_valid", 32'(out_valid), 32'd1);
    tick();
`endif

    // both ports write x3; port 1 wins. x0 writes and reservations are ignored
    set_wb(2'b11, 5'd3, 5'd3, 32'h1, 32'h2);
    tick();
    set_wb(2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0);
    issue(1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
    exp_q.push_back({32'h2, 32'h2});
    at_neg();
    check("t3_in_ready", 32'(in_ready), 32'd1);
    tick();
    set_wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    issue(1'b1, 5'd0, 5'd3, 5'd0, 1'b1);
    exp_q.push_back({32'h0, 32'h2});
    at_neg();
    check("t3_rd0_in_ready", 32'(in_ready), 32'd1);
    tick();
    issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    exp_q.push_back({32'h0, 32'h0});
    at_neg();
    check("t3_x0_never_busy", 32'(in_ready), 32'd1);
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    at_neg();
    tick();

    // output backpressure for 3 cycles, then release with a same-cycle accept
    out_ready = 1'b0;
    issue(1'b1, 5'd5, 5'd3, 5'd0, 1'b0);
    exp_q.push_back({32'hDEAD_BEEF, 32'h2});
    at_neg();
    tick();
    issue(1'b1, 5'd3, 5'd5, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("t4_hold_out_valid", 32'(out_valid), 32'd1);
      check("t4_hold_rs1", rs1_value, 32'hDEAD_BEEF);
      check("t4_hold_rs2", rs2_value, 32'h2);
      check("t4_hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    exp_stall += 3;
    out_ready = 1'b1;
    exp_q.push_back({32'h2, 32'hDEAD_BEEF});
    at_neg();
    check("t4_release_in_ready", 32'(in_ready), 32'd1);
    check("t4_stall", 32'(stall_cnt), 32'(exp_stall));
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    at_neg();
    check("t4_second_out_valid", 32'(out_valid), 32'd1);
    tick();

    // flush squashes busy x9 and the pending output but keeps the writeback
    out_ready = 1'b0;
    issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    at_neg();
    check("t5_rd9_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b1;
    issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    set_wb(2'b01, 5'd10, 5'd0, 32'hA5, 32'h0);
    at_neg();
    check("t5_flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    exp_stall += 1;
    flush = 1'b0;
    set_wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    issue(1'b1, 5'd9, 5'd10, 5'd0, 1'b0);
    out_ready = 1'b1;
    exp_q.push_back({32'h0, 32'hA5});
    at_neg();
    check("t5_out_valid_cleared", 32'(out_valid), 32'd0);
    check("t5_x9_in_ready", 32'(in_ready), 32'd1);
    check("t5_stall", 32'(stall_cnt), 32'(exp_stall));
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    at_neg();
    check("t5_out_valid", 32'(out_valid), 32'd1);
    tick();
    at_neg();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
